// File: rtl/pipeline_boot_ctrl.sv
// Boot sequencer: streams a program into instruction memory, NOP-fills the rest,
// then runs the core for a bounded window. Define BOOT_CHECKSUM_EN to add XOR load verification.
module pipeline_boot_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RUN_CYCLES = 37
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
`ifdef BOOT_CHECKSUM_EN
  input  logic [DATA_W-1:0] exp_sum,
  output logic              sum_ok,
`endif
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, HALT} state_e;

  localparam logic [ADDR_W:0]   LAST_CNT  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_C     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]       RUN_LIMIT = 32'(RUN_CYCLES);

  state_e              state_q, state_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                error_q, error_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [31:0]         cycle_count_q, cycle_count_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic                enter_run;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                sum_ok_q, sum_ok_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    im_we_d       = 1'b0;
    im_addr_d     = im_addr_q;
    im_wdata_d    = im_wdata_q;
    cpu_reset_d   = 1'b0;
    error_d       = error_q;
    word_count_d  = word_count_q;
    cycle_count_d = cycle_count_q;
    fill_addr_d   = fill_addr_q;
    enter_run     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d         = sum_q;
    sum_ok_d      = sum_ok_q;
`endif

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d       = LOAD;
          word_count_d  = '0;
          cycle_count_d = '0;
          error_d       = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_d         = '0;
`endif
        end
      end
      LOAD: begin
        if (s_valid) begin
          im_we_d      = 1'b1;
          im_addr_d    = word_count_q[ADDR_W-1:0];
          im_wdata_d   = s_data;
          word_count_d = word_count_q + ONE_C;
`ifdef BOOT_CHECKSUM_EN
          sum_d        = sum_q ^ s_data;
`endif
          if (word_count_q == LAST_CNT) begin
            if (s_last) begin
              enter_run = 1'b1;
            end else begin
              // Program overflowed memory: never release the core.
              error_d = 1'b1;
              state_d = HALT;
            end
          end else if (s_last) begin
            state_d     = FILL;
            fill_addr_d = word_count_q[ADDR_W-1:0] + ONE_A;
          end
        end
      end
      FILL: begin
        im_we_d     = 1'b1;
        im_addr_d   = fill_addr_q;
        im_wdata_d  = '0;
        fill_addr_d = fill_addr_q + ONE_A;
        if (fill_addr_q == ADDR_MAX) enter_run = 1'b1;
      end
      RUN: begin
        // The first RUN cycle lets the final memory write land before the core wakes.
        if (cpu_reset_q && cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
        if (RUN_CYCLES != 0 && cycle_count_d == RUN_LIMIT) state_d = HALT;
        cpu_reset_d = (state_d == RUN);
      end
      default: state_d = IDLE;
    endcase

    if (enter_run) begin
`ifdef BOOT_CHECKSUM_EN
      sum_ok_d = (sum_d == exp_sum);
      if (sum_d == exp_sum) begin
        state_d = RUN;
      end else begin
        error_d = 1'b1;
        state_d = HALT;
      end
`else
      state_d = RUN;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      im_we_q       <= 1'b0;
      im_addr_q     <= '0;
      im_wdata_q    <= '0;
      cpu_reset_q   <= 1'b0;
      error_q       <= 1'b0;
      word_count_q  <= '0;
      cycle_count_q <= '0;
      fill_addr_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q         <= '0;
      sum_ok_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      im_we_q       <= im_we_d;
      im_addr_q     <= im_addr_d;
      im_wdata_q    <= im_wdata_d;
      cpu_reset_q   <= cpu_reset_d;
      error_q       <= error_d;
      word_count_q  <= word_count_d;
      cycle_count_q <= cycle_count_d;
      fill_addr_q   <= fill_addr_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q         <= sum_d;
      sum_ok_q      <= sum_ok_d;
`endif
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q == LOAD) || (state_q == FILL) || (state_q == RUN);
  assign done        = (state_q == HALT);
  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign error       = error_q;
  assign word_count  = word_count_q;
  assign cycle_count = cycle_count_q;
`ifdef BOOT_CHECKSUM_EN
  assign sum_ok      = sum_ok_q;
`endif

endmodule

// File: tb/tb_pipeline_boot_ctrl.sv
// Directed bench for pipeline_boot_ctrl (depth 8, 37-cycle run window).
// Define BOOT_CHECKSUM_EN to also exercise the checksum ports.
module tb_pipeline_boot_ctrl;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int RC = 37;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready, im_we, cpu_reset, busy, done, error;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;
  logic [AW:0]   word_count;
  logic [31:0]   cycle_count;
`ifdef BOOT_CHECKSUM_EN
  logic [DW-1:0] exp_sum = '0;
  logic          sum_ok;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  logic [DW-1:0] prog [8] = '{32'hac020000, 32'h00430820, 32'h00a12023, 32'h00293824,
                              32'h00e13025, 32'h10670006, 32'h24ea0064, 32'h00a64024};

  pipeline_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RUN_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
`ifdef BOOT_CHECKSUM_EN
    .exp_sum(exp_sum), .sum_ok(sum_ok),
`endif
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Log of memory writes, sampled mid-cycle.
  always @(negedge clock) begin
    if (im_we) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int w = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && w < 20) begin
      tick();
      w++;
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake_timeout: s_ready got %b want 1", s_ready);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_reset: got %b want 0", cpu_reset); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL rst_im_we: got %b want 0", im_we); end
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, error}); end
    n_cmp++; if (word_count !== '0 || cycle_count !== '0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", word_count, cycle_count); end
`ifdef BOOT_CHECKSUM_EN
    n_cmp++; if (sum_ok !== 1'b0) begin n_bad++; $display("FAIL rst_sum_ok: got %b want 0", sum_ok); end
`endif
    reset = 1'b1;
    tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL idle_s_ready: got %b want 0", s_ready); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL start_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_full_load();
    int n = 0;
    do_reset(); do_start(); clear_log();
    for (int i = 0; i < 8; i++) send_word(prog[i], i == 7);
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL full_cpu_early: got %b want 0", cpu_reset); end
    tick();
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL full_cpu_rise: got %b want 1", cpu_reset); end
    n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL full_no_fill: im_we got %b want 0", im_we); end
    while (cpu_reset && n < 100) begin n++; tick(); end
    n_cmp++; if (n !== RC) begin n_bad++; $display("FAIL full_run_len: got %0d want %0d", n, RC); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL full_done: done/busy got %b%b want 10", done, busy); end
    n_cmp++; if (cycle_count !== 32'd37) begin n_bad++; $display("FAIL full_cycle_count: got %0d want 37", cycle_count); end
    n_cmp++; if (word_count !== 4'd8) begin n_bad++; $display("FAIL full_word_count: got %0d want 8", word_count); end
    n_cmp++; if (wr_addr_q.size() !== 8) begin n_bad++; $display("FAIL full_write_count: got %0d want 8", wr_addr_q.size()); end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      n_cmp++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== prog[i]) begin
        n_bad++;
        $display("FAIL full_write_%0d: got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, prog[i]);
      end
    end
  endtask

  task automatic test_fill();
    int n = 0;
    do_reset(); do_start(); clear_log();
    for (int i = 0; i < 3; i++) send_word(prog[i], i == 2);
    n_cmp++; if (im_we !== 1'b1 || im_addr !== 3'd2) begin n_bad++; $display("FAIL fill_last_load: got we=%b addr=%0d want we=1 addr=2", im_we, im_addr); end
    for (int k = 3; k < 8; k++) begin
      tick();
      n_cmp++;
      if (im_we !== 1'b1 || im_addr !== AW'(k) || im_wdata !== '0 || cpu_reset !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_nop_%0d: got we=%b addr=%0d data=%h cpu=%b want we=1 addr=%0d data=0 cpu=0",
                 k, im_we, im_addr, im_wdata, cpu_reset, k);
      end
    end
    tick();
    n_cmp++; if (cpu_reset !== 1'b1 || im_we !== 1'b0) begin n_bad++; $display("FAIL fill_cpu_rise: got cpu=%b we=%b want cpu=1 we=0", cpu_reset, im_we); end
    n_cmp++; if (word_count !== 4'd3) begin n_bad++; $display("FAIL fill_word_count: got %0d want 3", word_count); end
    n_cmp++; if (wr_addr_q.size() !== 8) begin n_bad++; $display("FAIL fill_write_count: got %0d want 8", wr_addr_q.size()); end
    while (!done && n < 100) begin n++; tick(); end
    n_cmp++; if (done !== 1'b1 || cycle_count !== 32'd37) begin n_bad++; $display("FAIL fill_halt: got done=%b cycles=%0d want done=1 cycles=37", done, cycle_count); end
  endtask

  task automatic test_overflow();
    logic rose = 1'b0;
    do_reset(); do_start(); clear_log();
    for (int i = 0; i < 8; i++) send_word(prog[i], 1'b0);
    n_cmp++; if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ovf_halt: got err/done/busy=%b%b%b want 110", error, done, busy); end
    for (int i = 0; i < 50; i++) begin rose |= cpu_reset; tick(); end
    n_cmp++; if (rose !== 1'b0) begin n_bad++; $display("FAIL ovf_cpu_held: got rise=%b want 0", rose); end
    n_cmp++; if (wr_addr_q.size() !== 8) begin n_bad++; $display("FAIL ovf_write_count: got %0d want 8", wr_addr_q.size()); end
    do_start();
    n_cmp++; if (error !== 1'b0 || word_count !== '0) begin n_bad++; $display("FAIL ovf_restart_clear: got err=%b wc=%0d want err=0 wc=0", error, word_count); end
    n_cmp++; if (s_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ovf_restart_load: got ready=%b done=%b want 1 0", s_ready, done); end
  endtask

  task automatic test_gaps();
    do_reset(); do_start(); clear_log();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word(32'h0000_0100 + DW'(i), 1'b0);
    end
    tick();
    n_cmp++; if (wr_addr_q.size() !== 4) begin n_bad++; $display("FAIL gap_write_count: got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      n_cmp++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== 32'h0000_0100 + DW'(i)) begin
        n_bad++;
        $display("FAIL gap_write_%0d: got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, 32'h100 + i);
      end
    end
    n_cmp++; if (s_ready !== 1'b1 || word_count !== 4'd4) begin n_bad++; $display("FAIL gap_start_ignored: got ready=%b wc=%0d want 1 4", s_ready, word_count); end
  endtask

  task automatic test_async_reset();
    do_reset(); do_start(); clear_log();
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0) begin n_bad++; $display("FAIL arst_im: got we=%b addr=%0d data=%h want 0 0 0", im_we, im_addr, im_wdata); end
    n_cmp++; if (s_ready !== 1'b0 || busy !== 1'b0 || word_count !== '0) begin n_bad++; $display("FAIL arst_state: got ready=%b busy=%b wc=%0d want 0 0 0", s_ready, busy, word_count); end
    #1;
    reset = 1'b1;
    tick();
    do_start();
    send_word(32'hdead_beef, 1'b0);
    n_cmp++; if (im_we !== 1'b1 || im_addr !== '0 || im_wdata !== 32'hdead_beef) begin n_bad++; $display("FAIL arst_reload: got we=%b addr=%0d data=%h want 1 0 deadbeef", im_we, im_addr, im_wdata); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int n = 0;
    logic rose = 1'b0;
    exp_sum = 32'h7;
    do_reset(); do_start();
    send_word(32'h1, 1'b0); send_word(32'h2, 1'b0); send_word(32'h4, 1'b1);
    while (!cpu_reset && !done && n < 30) begin n++; tick(); end
    n_cmp++; if (sum_ok !== 1'b1 || cpu_reset !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL sum_good: got ok=%b cpu=%b err=%b want 1 1 0", sum_ok, cpu_reset, error); end
    exp_sum = 32'h6;
    do_reset(); do_start();
    send_word(32'h1, 1'b0); send_word(32'h2, 1'b0); send_word(32'h4, 1'b1);
    n = 0;
    while (!done && n < 30) begin rose |= cpu_reset; n++; tick(); end
    for (int i = 0; i < 5; i++) begin rose |= cpu_reset; tick(); end
    n_cmp++; if (sum_ok !== 1'b0 || error !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL sum_bad: got ok=%b err=%b done=%b want 0 1 1", sum_ok, error, done); end
    n_cmp++; if (rose !== 1'b0) begin n_bad++; $display("FAIL sum_bad_cpu_held: got rise=%b want 0", rose); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_fill();
    test_overflow();
    test_gaps();
    test_async_reset();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_boot_ctrl.md
# pipeline_boot_ctrl

Parametrised boot controller that sits in front of the pipeline CPU's instruction memory and reset input. It accepts a program as a valid/ready word stream, writes it into instruction memory, and NOP-fills unused locations. It then releases the core from reset for a bounded run window and re-asserts core reset when the window expires. It replaces hand-preloading of instruction memory and fixed-delay reset release with a reusable, synthesizable sequencer.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words
- DATA_W, 32, instruction word width
- RUN_CYCLES, 37, core run-window length in clock cycles; 0 = unlimited

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin load; sampled only in IDLE or HALT
- s_valid  in  1  program word valid
- s_data  in  DATA_W  program word
- s_last  in  1  marks final program word
- s_ready  out  1  controller accepts a word
- im_we  out  1  instruction-memory write enable (registered)
- im_addr  out  ADDR_W  instruction-memory word address (registered)
- im_wdata  out  DATA_W  instruction-memory write data (registered)
- cpu_reset  out  1  active-low reset to the core; 0 = core held
- busy  out  1  state is LOAD, FILL or RUN
- done  out  1  state is HALT
- error  out  1  sticky load error; cleared by start or reset
- word_count  out  ADDR_W+1  words accepted in current load
- cycle_count  out  32  cycles spent in RUN

## Operation
- States: IDLE, LOAD, FILL, RUN, HALT.
- IDLE: s_ready=0, cpu_reset=0. start=1 -> LOAD; clears word_count, cycle_count and error.
- LOAD: s_ready=1. Handshake is s_valid & s_ready.
  - Each handshake registers im_we=1, im_addr=word_count and im_wdata=s_data, and increments word_count.
  - Handshake with s_last and word_count+1 < depth -> FILL.
  - Handshake with s_last and word_count+1 == depth -> RUN.
  - Handshake filling the last address without s_last -> error=1, HALT; the core is never released.
- FILL: each cycle writes im_wdata=0 (NOP) to im_addr=next unused address. Writes cover addresses word_count..depth-1, one per cycle, then -> RUN. s_ready=0.
- RUN: cpu_reset=1 and cycle_count increments each cycle. When RUN_CYCLES≠0 and cycle_count reaches RUN_CYCLES -> HALT.
- HALT: cpu_reset=0 and done=1. start=1 -> LOAD; the counter clears described for IDLE apply.
- start in LOAD, FILL or RUN is ignored.
- im_we is low in every state except the cycle after a LOAD handshake and during FILL.
- cycle_count saturates at 2**32-1.

## Timing
- Reset values: state=IDLE, s_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_reset=0, busy=0, done=0, error=0, word_count=0, cycle_count=0.
- Reset is asynchronous. Asserting it mid-operation forces all of the above immediately, including cpu_reset=0.
- start at edge t -> s_ready=1 from t+1.
- Handshake at edge t -> im_we/im_addr/im_wdata valid in cycle t+1.
- Last LOAD write or last FILL write at edge t -> cpu_reset=1 from edge t+1.
- Load of n<depth words: FILL lasts depth-n cycles.
- RUN lasts exactly RUN_CYCLES cycles. cpu_reset falls and done rises on the same edge; cycle_count then equals RUN_CYCLES.
- s_valid gaps are allowed; only handshakes count.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - Adds input exp_sum (DATA_W) and output sum_ok (1).
  - Maintains an XOR of all accepted words; the accumulator is cleared on start and on reset.
  - On the edge that would enter RUN, sum_ok = (xor == exp_sum).
  - Mismatch -> error=1, go to HALT; cpu_reset stays 0.
  - sum_ok resets to 0.
- BOOT_CHECKSUM_EN undefined: no exp_sum or sum_ok ports and no accumulator; error flags only the overflow case.

## Test plan
All scenarios use ADDR_W=3 (depth 8) and RUN_CYCLES=37.
- Reset held low -> cpu_reset=0, s_ready=0, im_we=0, busy=0, done=0, counts 0. Release and start -> s_ready=1 one cycle later.
- Stream 8 words 0xac020000, 0x00430820, 0x00a12023, 0x00293824, 0x00e13025, 0x10670006, 0x24ea0064, 0x00a64024, with s_last on the 8th:
  - Writes occur at addresses 0..7, with no FILL.
  - cpu_reset=1 one cycle after the last write, for 37 cycles.
  - Then done=1 and cycle_count=37.
- Stream 3 words with s_last on the 3rd -> five consecutive writes of 0x00000000 to addresses 3..7, then cpu_reset=1. word_count=3.
- Stream 8 words without s_last -> error=1, HALT, and cpu_reset never rises. A subsequent start clears error and word_count.
- Stream with s_valid toggled every other cycle, plus start pulsed during LOAD -> exactly one write per handshake at sequential addresses, and start is ignored. Reset low after 2 words -> immediate reset values, and the next load begins at address 0.
- With BOOT_CHECKSUM_EN, stream 0x1, 0x2, 0x4 (s_last on 0x4):
  - exp_sum=0x7 -> sum_ok=1 and RUN entered.
  - exp_sum=0x6 -> sum_ok=0, error=1, HALT, and cpu_reset stays 0.
